icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipelined datapath fetch
//  stage and the memory controller. Serves imemload/ihit to fetch on a hit. On a
//  miss it runs a one-word refill from memory and then replays the lookup as a hit.
//  Stores are never seen; instruction memory is treated as immutable.
// PARAMETERS
//  SETS     16  number of frames, power of 2; IDX_W = $clog2(SETS)
//  TAG_W    30-IDX_W  tag width, derived; addr[31:IDX_W+2]
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  RST        in   1   synchronous, active-high reset
//  imemREN    in   1   fetch request from datapath
//  imemaddr   in   32  word-aligned fetch address; [1:0] ignored
//  imemload   out  32  instruction returned; valid only when ihit=1
//  ihit       out  1   hit strobe, combinational from lookup
//  iREN       out  1   refill read request to memory controller
//  iaddr      out  32  refill address, {miss_tag, miss_idx, 2'b00}
//  iload      in   32  refill data from memory controller
//  iwait      in   1   memory busy; data valid in a cycle with iREN=1 and iwait=0
// BEHAVIOUR
//  - Arrays: valid[SETS], tag[SETS][TAG_W], data[SETS][32]; idx=addr[IDX_W+1:2].
//  - FSM states: IDLE, FETCH.
//  - IDLE: ihit = imemREN & valid[idx] & (tag[idx]==addr tag); imemload = data[idx].
//    Miss (imemREN & !hit): latch imemaddr into miss_addr, next state FETCH.
//    imemREN=0: ihit=0, no state change.
//  - FETCH: ihit=0; iREN=1; iaddr=miss_addr. Stays while iwait=1. On iwait=0:
//    data/tag of miss_idx <= iload/miss tag, valid <= 1, next state IDLE.
//  - Miss timing: miss seen cycle 0; iREN high from cycle 1; N cycles of iwait=1
//    then one cycle with iwait=0 (fill); ihit=1 in cycle N+2 if imemaddr unchanged.
//  - imemaddr changes or imemREN drops during FETCH: the refill still completes to
//    miss_addr. The new address is looked up in IDLE afterwards.
//  - Outputs in IDLE with no request: iREN=0, iaddr=0, ihit=0, imemload=data[idx].
//  - Reset (any state, including mid-FETCH): next cycle state=IDLE, all valid=0,
//    miss_addr=0, iREN=0, ihit=0. Tag/data arrays are not cleared.
//  - Refill to an occupied frame overwrites it (no victim handling; read-only).
//  - iwait=0 in IDLE is ignored. iload is sampled only in FETCH.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
//   hit_count +1 for each IDLE cycle with ihit=1.
//   miss_count +1 on each IDLE->FETCH transition.
//   Both wrap modulo 2^32 and are cleared by RST.
//  Not defined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//  1 RST=1 2 cycles, then imemaddr=0x0 REN=1 -> ihit=0, FETCH, iREN=1, iaddr=0x0
//  2 iwait=1 for 3 cycles, then iwait=0 with iload=0x2001000A -> next cycle
//    ihit=1, imemload=0x2001000A. Again at 0x0 -> ihit=1 the same cycle, iREN=0.
//  3 Conflict (SETS=16): fill 0x04, then fetch 0x44 (same idx 1) -> miss, refill.
//    Re-fetch 0x04 -> miss again.
//  4 During FETCH for 0x08, change imemaddr to 0x10 -> iaddr stays 0x08.
//    After the fill, 0x10 misses and 0x08 later hits.
//  5 Assert RST mid-FETCH -> next cycle iREN=0, state IDLE. Prior filled 0x0
//    now misses.
//  6 With ICACHE_STATS_EN: sequence of scenario 2 -> miss_count=1, hit_count=2.
//    After RST both are 0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a one-word refill FSM.
// Defining ICACHE_STATS_EN adds the hit_count/miss_count outputs.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t           state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];
  logic [29:0]      miss_addr;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] miss_tag;
  logic             lookup;
  logic             miss;
  logic             unused_bits;

  assign idx         = imemaddr[IDX_W+1:2];
  assign tag         = imemaddr[31:IDX_W+2];
  assign miss_idx    = miss_addr[IDX_W-1:0];
  assign miss_tag    = miss_addr[29:IDX_W];
  assign unused_bits = ^imemaddr[1:0];

  // Lookup is only meaningful in IDLE; FETCH never reports a hit.
  assign lookup   = valid[idx] && (tag_mem[idx] == tag);
  assign ihit     = (state == IDLE) && imemREN && lookup;
  assign miss     = (state == IDLE) && imemREN && !lookup;
  assign imemload = data_mem[idx];

  // Refill FSM; tag/data arrays are intentionally left untouched by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      iREN      <= 1'b0;
      iaddr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state     <= FETCH;
            miss_addr <= imemaddr[31:2];
            iREN      <= 1'b1;
            iaddr     <= {imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          if (!iwait) begin
            state              <= IDLE;
            valid[miss_idx]    <= 1'b1;
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= iload;
            iREN               <= 1'b0;
            iaddr              <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a frame-table model.
// Define ICACHE_STATS_EN for both bench and RTL to exercise the counters.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .imemload(imemload), .ihit(ihit), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Model: which word address each frame currently holds.
  bit          frame_ok   [16];
  logic [29:0] frame_word [16];
  int unsigned model_hits = 0;
  int unsigned model_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    if (w == 32'd0) return 32'h2001000A;
    return (w * 32'h9E3779B1) ^ 32'h00005A5A;
  endfunction

  function automatic int fidx(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, model_hits);
    check("miss_count", miss_count, model_miss);
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) frame_ok[i] = 1'b0;
    model_hits = 0;
    model_miss = 0;
  endtask

  // One lookup of addr; on a miss, nwait busy cycles then a fill, with
  // imemaddr driven to alt (and imemREN optionally dropped) during FETCH.
  task automatic fetch(input logic [31:0] addr, input int nwait,
                       input logic [31:0] alt, input bit drop);
    bit h;
    int fi;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'($urandom_range(0, 1));
    iload    = $urandom;
    fi = fidx(addr);
    h  = frame_ok[fi] && (frame_word[fi] == addr[31:2]);
    @(negedge CLK);
    check("ihit_lookup", {31'd0, ihit}, {31'd0, h});
    check("iREN_idle", {31'd0, iREN}, 32'd0);
    if (h) begin
      check("imemload", imemload, memf(addr));
      model_hits++;
      @(posedge CLK); #1;
      check_stats();
      return;
    end
    model_miss++;
    @(posedge CLK); #1;
    for (int k = 0; k <= nwait; k++) begin
      imemaddr = alt;
      imemREN  = !drop;
      iwait    = (k < nwait);
      iload    = (k < nwait) ? $urandom : memf(addr);
      @(negedge CLK);
      check("iREN_fetch", {31'd0, iREN}, 32'd1);
      check("iaddr_fetch", iaddr, {addr[31:2], 2'b00});
      check("ihit_fetch", {31'd0, ihit}, 32'd0);
      @(posedge CLK); #1;
    end
    iwait = 1'b1;
    frame_ok[fi]   = 1'b1;
    frame_word[fi] = addr[31:2];
    check_stats();
  endtask

  // Cycle with no request: no hit, no refill, imemload reflects frame contents.
  task automatic idle_cycle(input logic [31:0] addr);
    int fi;
    imemREN  = 1'b0;
    imemaddr = addr;
    iwait    = 1'($urandom_range(0, 1));
    iload    = $urandom;
    fi = fidx(addr);
    @(negedge CLK);
    check("ihit_idle", {31'd0, ihit}, 32'd0);
    check("iREN_noreq", {31'd0, iREN}, 32'd0);
    check("iaddr_noreq", iaddr, 32'd0);
    if (frame_ok[fi]) check("imemload_idle", imemload, memf({frame_word[fi], 2'b00}));
    @(posedge CLK); #1;
  endtask

  // Start a miss, reset during FETCH, and confirm the cache came back empty.
  task automatic reset_mid_fetch(input logic [31:0] addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("iREN_prerst", {31'd0, iREN}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST     = 1'b0;
    imemREN = 1'b0;
    clear_model();
    @(negedge CLK);
    check("iREN_postrst", {31'd0, iREN}, 32'd0);
    check("iaddr_postrst", iaddr, 32'd0);
    check("ihit_postrst", {31'd0, ihit}, 32'd0);
    check_stats();
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iload    = '0;
    iwait    = 1'b1;
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_iREN", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check_stats();
    RST = 1'b0;

    // Cold miss at 0x0 with three busy cycles, then two hits.
    fetch(32'h0, 3, 32'h0, 1'b0);
    fetch(32'h0, 0, 32'h0, 1'b0);
    fetch(32'h0, 0, 32'h0, 1'b0);
`ifdef ICACHE_STATS_EN
    check("stats_miss1", miss_count, 32'd1);
    check("stats_hit2", hit_count, 32'd2);
`endif

    // Conflict on frame 1.
    fetch(32'h04, 1, 32'h04, 1'b0);
    fetch(32'h04, 0, 32'h04, 1'b0);
    fetch(32'h44, 2, 32'h44, 1'b0);
    fetch(32'h04, 0, 32'h04, 1'b0);

    // Address moves during FETCH; refill still targets 0x08.
    fetch(32'h08, 2, 32'h10, 1'b0);
    fetch(32'h10, 1, 32'h10, 1'b0);
    fetch(32'h08, 0, 32'h08, 1'b0);
    fetch(32'h0C, 1, 32'h0C, 1'b1);
    idle_cycle(32'h0C);

    // Reset during a refill empties the cache.
    fetch(32'h0, 0, 32'h0, 1'b0);
    reset_mid_fetch(32'h20);
    fetch(32'h0, 1, 32'h0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      b = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      case ($urandom_range(0, 5))
        0:       idle_cycle(a);
        1:       fetch(a, int'($urandom_range(0, 3)), b, 1'($urandom_range(0, 1)));
        default: fetch(a, int'($urandom_range(0, 3)), a, 1'b0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
